// File: rtl/alu_pkg.sv
// Shared ALU constants: select codes used by the ALU control decoder and the
// execute stage, plus the execute-stage FSM state encoding.
package alu_pkg;

    // ALU select codes
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_SLT  = 4'b1010;
    localparam logic [3:0] ALU_SLTU = 4'b1011;

    // Execute-stage FSM states
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // True for the three shift select codes
    function automatic logic is_shift_op(input logic [3:0] sel);
        return (sel == ALU_SLL) || (sel == ALU_SRL) || (sel == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// One-bit-per-cycle shifter: shift register plus down-counter. done is high
// during the cycle whose clock edge performs the last shift; shift_next is the
// value the register takes on that edge, so the owner captures it directly.
// clear (synchronous) abandons any shift in progress.
module alu_serial_shifter #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               start,
    input  logic               shift_left,
    input  logic               arith,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [XLEN-1:0]    data,
    output logic [XLEN-1:0]    shift_next,
    output logic               done
);
    import alu_pkg::*;

    localparam logic [SHAMT_W-1:0] CNT_ZERO = {SHAMT_W{1'b0}};
    localparam logic [SHAMT_W-1:0] CNT_ONE  = {{(SHAMT_W-1){1'b0}}, 1'b1};

    logic [XLEN-1:0]    shreg_r;
    logic [SHAMT_W-1:0] cnt_r;
    logic               left_r;
    logic               arith_r;

    // Single-step shift of the current register contents; SRA refills with the MSB
    always_comb begin
        shift_next = shreg_r;
        if (left_r) begin
            shift_next = {shreg_r[XLEN-2:0], 1'b0};
        end else begin
            shift_next = {(arith_r & shreg_r[XLEN-1]), shreg_r[XLEN-1:1]};
        end
    end

    assign done = (cnt_r == CNT_ONE);

    // Load on start, then shift and count down until the counter empties
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_r <= {XLEN{1'b0}};
            cnt_r   <= CNT_ZERO;
            left_r  <= 1'b0;
            arith_r <= 1'b0;
        end else if (clear) begin
            cnt_r   <= CNT_ZERO;
        end else if (start) begin
            shreg_r <= data;
            cnt_r   <= shamt;
            left_r  <= shift_left;
            arith_r <= arith;
        end else if (cnt_r != CNT_ZERO) begin
            shreg_r <= shift_next;
            cnt_r   <= cnt_r - CNT_ONE;
        end else begin
            shreg_r <= shreg_r;
        end
    end

endmodule

// File: rtl/alu_seq_exec.sv
// Execute-stage ALU with valid/ready handshakes. Logic, arithmetic and compare
// ops finish in one cycle; shifts use a serial shifter (one bit per cycle) and
// hold the unit busy. Build option ALU_BARREL_SHIFT_EN swaps in a
// combinational barrel shifter so shifts also finish in one cycle.
module alu_seq_exec #(
    parameter  int XLEN    = 32,
    localparam int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_sel,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);
    import alu_pkg::*;

    logic               out_valid_r;
    logic [XLEN-1:0]    result_r;
    logic               zero_r;
    logic [XLEN-1:0]    comb_res_s;
    logic [SHAMT_W-1:0] shamt_s;
    logic               accept_s;
    logic               in_ready_s;

    assign shamt_s  = op_b[SHAMT_W-1:0];
    assign accept_s = in_valid && in_ready_s;

    // Single-cycle result for the requested op (shifts by zero pass op_a in the serial build)
    always_comb begin
        comb_res_s = {XLEN{1'b0}};
        case (alu_sel)
            ALU_AND:  comb_res_s = op_a & op_b;
            ALU_OR:   comb_res_s = op_a | op_b;
            ALU_ADD:  comb_res_s = op_a + op_b;
            ALU_SUB:  comb_res_s = op_a - op_b;
            ALU_XOR:  comb_res_s = op_a ^ op_b;
            ALU_SLT:  comb_res_s = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: comb_res_s = {{(XLEN-1){1'b0}}, (op_a < op_b)};
`ifdef ALU_BARREL_SHIFT_EN
            ALU_SLL:  comb_res_s = op_a << shamt_s;
            ALU_SRL:  comb_res_s = op_a >> shamt_s;
            ALU_SRA:  comb_res_s = $unsigned($signed(op_a) >>> shamt_s);
`else
            ALU_SLL:  comb_res_s = op_a;
            ALU_SRL:  comb_res_s = op_a;
            ALU_SRA:  comb_res_s = op_a;
`endif
            default:  comb_res_s = {XLEN{1'b0}};
        endcase
    end

`ifdef ALU_BARREL_SHIFT_EN

    assign in_ready_s = (!out_valid_r || out_ready) && !flush;
    assign busy       = 1'b0;

    // Result register and output-valid tracking; every op has latency 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            result_r    <= {XLEN{1'b0}};
            zero_r      <= 1'b0;
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else if (accept_s) begin
            result_r    <= comb_res_s;
            zero_r      <= (comb_res_s == {XLEN{1'b0}});
            out_valid_r <= 1'b1;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

`else

    logic [0:0]      state_r;
    logic            start_s;
    logic            done_s;
    logic [XLEN-1:0] shift_next_s;

    assign in_ready_s = (state_r == ST_IDLE) && (!out_valid_r || out_ready) && !flush;
    assign busy       = (state_r != ST_IDLE);
    assign start_s    = accept_s && is_shift_op(alu_sel) && (shamt_s != {SHAMT_W{1'b0}});

    alu_serial_shifter #(
        .XLEN    (XLEN),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (flush),
        .start      (start_s),
        .shift_left (alu_sel == ALU_SLL),
        .arith      (alu_sel == ALU_SRA),
        .shamt      (shamt_s),
        .data       (op_a),
        .shift_next (shift_next_s),
        .done       (done_s)
    );

    // FSM, result register and output-valid tracking; flush overrides everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            result_r    <= {XLEN{1'b0}};
            zero_r      <= 1'b0;
        end else if (flush) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_r     <= ST_SHIFT;
                        out_valid_r <= 1'b0;
                    end else if (accept_s) begin
                        result_r    <= comb_res_s;
                        zero_r      <= (comb_res_s == {XLEN{1'b0}});
                        out_valid_r <= 1'b1;
                    end else if (out_valid_r && out_ready) begin
                        out_valid_r <= 1'b0;
                    end else begin
                        out_valid_r <= out_valid_r;
                    end
                end
                ST_SHIFT: begin
                    if (done_s) begin
                        result_r    <= shift_next_s;
                        zero_r      <= (shift_next_s == {XLEN{1'b0}});
                        out_valid_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r     <= ST_SHIFT;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

`endif

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign zero      = zero_r;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed self-checking bench for alu_seq_exec. Honours ALU_BARREL_SHIFT_EN
// for shift latency expectations.
module tb_alu_seq_exec;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_sel;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        busy;

    int n_cmp;
    int n_err;

    alu_seq_exec #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_sel   (alu_sel),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        alu_sel  = s;
        op_a     = a;
        op_b     = b;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_op(ALU_ADD, 32'h1, 32'h1);
        repeat (3) tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL reset_result got %h want 00000000", result); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_cmp++; if (zero !== 1'b0) begin n_err++; $display("FAIL reset_zero got %0b want 0", zero); end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    endtask

    task automatic test_add_sub_b2b();
        out_ready = 1'b1;
        set_op(ALU_ADD, 32'h7FFF_FFFF, 32'h1);
        tick();
        n_cmp++; if (out_valid !== 1'b1 || result !== 32'h8000_0000 || zero !== 1'b0) begin
            n_err++; $display("FAIL add_wrap got v=%0b r=%h z=%0b want v=1 r=80000000 z=0", out_valid, result, zero);
        end
        set_op(ALU_SUB, 32'h5, 32'h5);
        tick();
        n_cmp++; if (out_valid !== 1'b1 || result !== 32'h0 || zero !== 1'b1) begin
            n_err++; $display("FAIL sub_zero got v=%0b r=%h z=%0b want v=1 r=00000000 z=1", out_valid, result, zero);
        end
        set_op(ALU_SUB, 32'h3, 32'h5);
        tick();
        n_cmp++; if (result !== 32'hFFFF_FFFE || zero !== 1'b0) begin
            n_err++; $display("FAIL sub_wrap got r=%h z=%0b want r=fffffffe z=0", result, zero);
        end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain got %0b want 0", out_valid); end
    endtask

    task automatic test_logic_compare();
        out_ready = 1'b1;
        set_op(ALU_AND, 32'hF0F0_1234, 32'h0FF0_FFFF);
        tick();
        n_cmp++; if (result !== 32'h00F0_1234) begin n_err++; $display("FAIL and got %h want 00f01234", result); end
        set_op(ALU_OR, 32'hF000_0001, 32'h0000_0F00);
        tick();
        n_cmp++; if (result !== 32'hF000_0F01) begin n_err++; $display("FAIL or got %h want f0000f01", result); end
        set_op(ALU_SLT, 32'hFFFF_FFFF, 32'h1);
        tick();
        n_cmp++; if (result !== 32'h1 || zero !== 1'b0) begin n_err++; $display("FAIL slt got r=%h z=%0b want r=00000001 z=0", result, zero); end
        set_op(ALU_SLTU, 32'hFFFF_FFFF, 32'h1);
        tick();
        n_cmp++; if (result !== 32'h0 || zero !== 1'b1) begin n_err++; $display("FAIL sltu got r=%h z=%0b want r=00000000 z=1", result, zero); end
        set_op(4'b1111, 32'h1234_5678, 32'h1);
        tick();
        n_cmp++; if (out_valid !== 1'b1 || result !== 32'h0 || zero !== 1'b1) begin
            n_err++; $display("FAIL bad_code got v=%0b r=%h z=%0b want v=1 r=00000000 z=1", out_valid, result, zero);
        end
        set_op(ALU_SLL, 32'h1234_5678, 32'h20);
        tick();
        n_cmp++; if (out_valid !== 1'b1 || result !== 32'h1234_5678 || busy !== 1'b0) begin
            n_err++; $display("FAIL shamt0 got v=%0b r=%h b=%0b want v=1 r=12345678 b=0", out_valid, result, busy);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_sra();
        int lat;
        out_ready = 1'b1;
        set_op(ALU_SRA, 32'h8000_0000, 32'h4);
        tick();
        in_valid = 1'b0;
        lat = 0;
`ifndef ALU_BARREL_SHIFT_EN
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
                n_err++; $display("FAIL sra_busy[%0d] got b=%0b ir=%0b v=%0b want b=1 ir=0 v=0", k, busy, in_ready, out_valid);
            end
            tick();
            lat++;
        end
        n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL sra_latency got %0d want 4", lat); end
`endif
        n_cmp++; if (out_valid !== 1'b1 || result !== 32'hF800_0000 || busy !== 1'b0 || zero !== 1'b0) begin
            n_err++; $display("FAIL sra_result got v=%0b r=%h b=%0b z=%0b want v=1 r=f8000000 b=0 z=0", out_valid, result, busy, zero);
        end
        tick();
    endtask

    task automatic test_shift_misc();
        logic [3:0]  s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
        int          want_lat;
        int          lat;
        out_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            case (t)
                0: begin s = ALU_SLL; a = 32'h1;         b = 32'h23; e = 32'h8;         want_lat = 3;  end
                1: begin s = ALU_SRL; a = 32'h8000_0000; b = 32'h1F; e = 32'h1;         want_lat = 31; end
                2: begin s = ALU_SRA; a = 32'h7FFF_FFF0; b = 32'h4;  e = 32'h07FF_FFFF; want_lat = 4;  end
                default: begin s = ALU_SRL; a = 32'hF; b = 32'h5;    e = 32'h0;         want_lat = 5;  end
            endcase
`ifdef ALU_BARREL_SHIFT_EN
            want_lat = 0;
`endif
            set_op(s, a, b);
            tick();
            in_valid = 1'b0;
            lat = 0;
            while (out_valid !== 1'b1 && lat < 64) begin
                tick();
                lat++;
            end
            n_cmp++; if (lat !== want_lat) begin n_err++; $display("FAIL shift%0d_latency got %0d want %0d", t, lat, want_lat); end
            n_cmp++; if (result !== e || zero !== (e == 32'h0)) begin
                n_err++; $display("FAIL shift%0d_result got r=%h z=%0b want r=%h z=%0b", t, result, zero, e, (e == 32'h0));
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        set_op(ALU_XOR, 32'hF0F0, 32'h0FF0);
        tick();
        set_op(ALU_ADD, 32'h1, 32'h2);
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (out_valid !== 1'b1 || result !== 32'hFF00 || in_ready !== 1'b0) begin
                n_err++; $display("FAIL bp_hold[%0d] got v=%0b r=%h ir=%0b want v=1 r=0000ff00 ir=0", k, out_valid, result, in_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got %0b want 1", in_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b1 || result !== 32'h3) begin
            n_err++; $display("FAIL bp_resume got v=%0b r=%h want v=1 r=00000003", out_valid, result);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        logic seen;
        out_ready = 1'b1;
        set_op(ALU_SLL, 32'h1, 32'hA);
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        flush = 1'b1;
        set_op(ALU_ADD, 32'd100, 32'd200);
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready got %0b want 0", in_ready); end
        tick();
        flush = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL flush_idle got v=%0b b=%0b want v=0 b=0", out_valid, busy);
        end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || result !== 32'd300) begin
            n_err++; $display("FAIL flush_next_add got v=%0b r=%h want v=1 r=0000012c", out_valid, result);
        end
        tick();
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (out_valid !== 1'b0) seen = 1'b1;
            tick();
        end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL flush_stale got out_valid seen=%0b want 0", seen); end
    endtask

    task automatic test_reset_mid_shift();
        logic seen;
        out_ready = 1'b1;
        set_op(ALU_SRA, 32'h8000_0000, 32'd20);
        tick();
        in_valid = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0 || result !== 32'h0) begin
            n_err++; $display("FAIL rst_mid got v=%0b b=%0b r=%h want v=0 b=0 r=00000000", out_valid, busy, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 25; k++) begin
            if (out_valid !== 1'b0) seen = 1'b1;
            tick();
        end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL rst_mid_stale got out_valid seen=%0b want 0", seen); end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        alu_sel   = 4'b0000;
        op_a      = 32'h0;
        op_b      = 32'h0;
        test_reset();
        test_add_sub_b2b();
        test_logic_compare();
        test_sra();
        test_shift_misc();
        test_backpressure();
        test_flush();
        test_reset_mid_shift();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_seq_exec.md
Name: alu_seq_exec

Overview:
- Execute-stage consumer of the 4-bit ALU select code produced by the ALU control decoder.
- Performs the selected operation on two XLEN operands and returns a registered result plus a zero flag.
- Logic ops, arithmetic ops and compares complete in one cycle.
- Shifts use an area-saving serial shifter, one bit per cycle, so the unit exposes valid/ready handshakes that let the pipeline stall on it.

Parameters:
- XLEN, 32, operand/result width.
- SHAMT_W, $clog2(XLEN), shift-amount width; derived, not overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous kill of in-flight op and pending result (branch redirect).
- in_valid  input  1  operation request.
- in_ready  output  1  unit can accept a request this cycle.
- alu_sel  input  4  operation code.
- op_a  input  XLEN  operand A.
- op_b  input  XLEN  operand B; for shifts, shift amount is op_b[SHAMT_W-1:0].
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- result  output  XLEN  operation result.
- zero  output  1  result == 0; drives branch resolution.
- busy  output  1  state != IDLE; hazard-unit hint.

Behaviour:
- Codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0100 XOR.
  - 0111 SLL, 1000 SRL, 1001 SRA.
  - 1010 SLT (signed), 1011 SLTU (unsigned). Compare result is zero-extended 0/1.
  - All other codes: result 0, zero 1, latency 1.
- Arithmetic: ADD/SUB wrap modulo 2^XLEN; no overflow flag. Shift amount uses only low SHAMT_W bits of op_b.
- Reset (rst_n low, async): state IDLE, out_valid 0, result 0, zero 0, busy 0, counter 0. in_ready is 1 one cycle after reset release.
- Handshake:
  - Accept occurs when in_valid && in_ready at a clock edge.
  - in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
  - A result transfers when out_valid && out_ready.
  - result and zero are stable while out_valid && !out_ready.
- FSM states: IDLE, SHIFT.
  - IDLE, accept of a non-shift op, or a shift with shamt==0: result registered; out_valid=1 next cycle (latency 1). Stays IDLE.
  - IDLE, accept of a shift with shamt>0: latch op_a into the shift register, shamt into the down-counter, and the direction/arith bit. Go to SHIFT.
  - SHIFT: shift one bit per cycle; SRA replicates the MSB. Decrement the counter. When the counter reaches 1, write the final value, set out_valid, return to IDLE. Total latency is shamt cycles from accept to out_valid.
- Back-to-back: a new accept may occur in the same cycle the previous result is consumed. Throughput is 1/cycle for non-shift ops.
- Flush: on a clock edge with flush=1, state goes to IDLE, out_valid 0, counter 0. Any concurrent in_valid is ignored and any concurrent out_ready transfer does not count. Flush has priority over all other events.
- Reset mid-SHIFT: the operation is discarded with no output.
- zero is computed from the final result, registered alongside it.

Optional Feature:
- Macro: ALU_BARREL_SHIFT_EN.
- Defined: shifts use a combinational barrel shifter and complete with latency 1 like other ops. The SHIFT state and counter are not generated; busy is tied 0.
- Undefined: serial shifter as above.
- The external interface is identical in both builds.

Decomposition:
- Shared package alu_pkg:
  - 4-bit localparams for every ALU select code: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU.
  - FSM state encoding.
- The ALU control decoder imports the same constants.
- One sub-module: alu_serial_shifter (shift register, down-counter, done pulse), instantiated only when ALU_BARREL_SHIFT_EN is undefined.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, result=0, busy=0. One cycle after release, in_ready=1.
- ADD then SUB back-to-back, out_ready=1:
  - 0x7FFFFFFF+1 -> result 0x80000000, zero 0, next cycle.
  - 5-5 -> result 0, zero 1, on the following cycle.
- SRA: op_a=0x80000000, op_b=4 -> busy for 4 cycles, in_ready=0, then result 0xF8000000, out_valid=1 exactly 4 cycles after accept. With ALU_BARREL_SHIFT_EN defined: 1 cycle.
- Compares: SLT -1 vs 1 -> result 1. SLTU 0xFFFFFFFF vs 1 -> result 0. Shift with shamt=0 (op_b=0x20) -> result = op_a, latency 1.
- Backpressure: out_ready=0 for 3 cycles after XOR 0xF0F0 ^ 0x0FF0 -> result holds 0xFF00, in_ready=0; accept resumes the cycle out_ready=1.
- Flush during SLL shamt=10 at cycle 3 -> no out_valid, state IDLE; the next ADD accepted the following cycle returns the correct sum.
